// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_burst_reader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } rd_state_t;

   localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_reader_skid2.sv
// Two-entry output buffer with a last-beat sideband; head drives the stream.
module stream_skid2
   import fifo_burst_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  push_last,
   input  logic                  pop,
   output logic [1:0]            occ,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  last
);

   logic [1:0]            occ_q, occ_d;
   logic [DATA_WIDTH-1:0] hd_q, hd_d;
   logic [DATA_WIDTH-1:0] td_q, td_d;
   logic                  hl_q, hl_d;
   logic                  tl_q, tl_d;
   logic                  pop_ok;
   logic                  push_ok;
   logic                  full;

   assign full    = (occ_q == 2'(SKID_DEPTH));
   assign pop_ok  = pop && (occ_q != 2'd0);
   assign push_ok = push && (!full || pop_ok);

   // Head keeps its old contents when emptied so idle data holds steady.
   always_comb begin
      occ_d = occ_q;
      hd_d  = hd_q;
      hl_d  = hl_q;
      td_d  = td_q;
      tl_d  = tl_q;
      unique case ({push_ok, pop_ok})
         2'b10: begin
            if (occ_q == 2'd0) begin
               hd_d = push_data;
               hl_d = push_last;
            end else begin
               td_d = push_data;
               tl_d = push_last;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            if (full) begin
               hd_d = td_q;
               hl_d = tl_q;
            end
            occ_d = occ_q - 2'd1;
         end
         2'b11: begin
            if (full) begin
               hd_d = td_q;
               hl_d = tl_q;
               td_d = push_data;
               tl_d = push_last;
            end else begin
               hd_d = push_data;
               hl_d = push_last;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= 2'd0;
         hd_q  <= '0;
         hl_q  <= 1'b0;
         td_q  <= '0;
         tl_q  <= 1'b0;
      end else begin
         occ_q <= occ_d;
         hd_q  <= hd_d;
         hl_q  <= hl_d;
         td_q  <= td_d;
         tl_q  <= tl_d;
      end
   end

   assign occ   = occ_q;
   assign valid = (occ_q != 2'd0);
   assign data  = hd_q;
   assign last  = valid && hl_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops exactly len words from a registered-output FIFO and streams them out.
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_rden,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   rd_state_t            state_q, state_d;
   logic [LEN_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic                 inflight_q, inflight_d;
   logic                 done_q, done_d;
   logic [1:0]           occ;
   logic                 pop;
   logic                 cap_last;
   logic [2:0]           fill;

   assign pop  = m_valid && m_ready;
   assign fill = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

   // Fill counts words already promised to the buffer after this edge.
   assign fifo_rden = (state_q == RUN) && (rd_cnt_q != '0) &&
                      !fifo_empty && (fill < 3'(SKID_DEPTH));

   assign inflight_d = fifo_rden;
   assign cap_last   = inflight_q && (rd_cnt_q == '0);

   stream_skid2 #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight_q),
      .push_data(fifo_data),
      .push_last(cap_last),
      .pop      (pop),
      .occ      (occ),
      .valid    (m_valid),
      .data     (m_data),
      .last     (m_last)
   );

   always_comb begin
      state_d    = state_q;
      rd_cnt_d   = rd_cnt_q;
      beat_cnt_d = beat_cnt_q;
      done_d     = 1'b0;
      if (fifo_rden) begin
         rd_cnt_d = rd_cnt_q - LEN_WIDTH'(1);
      end
      if (pop && (beat_cnt_q != '0)) begin
         beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
      end
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  rd_cnt_d   = len;
                  beat_cnt_d = len;
                  state_d    = RUN;
               end
            end
         end
         RUN: begin
            if (fifo_rden && (rd_cnt_q == LEN_WIDTH'(1))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && (beat_cnt_q == LEN_WIDTH'(1))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_cnt_q   <= '0;
         beat_cnt_q <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench: queue-based FIFO upstream, word-order scoreboard, per-cycle checks.
module tb_fifo_burst_reader;

   localparam int DW = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          busy;
   logic          done;
   logic          fifo_rden;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_empty = 1'b1;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic          m_last;

   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] fifo_mem[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   logic [DW-1:0] wr_log[$];
   logic [DW-1:0] got[$];
   int            acc_cyc[$];
   bit            exp_busy = 1'b0;
   bit            exp_done = 1'b0;
   int            owed = 0;
   int            burst_len = 0;
   int            pops = 0;
   int            outst = 0;
   int            st_cyc = 0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   bit            pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   fifo_burst_reader #(
      .DATA_WIDTH(DW),
      .LEN_WIDTH (LW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .fifo_rden (fifo_rden),
      .fifo_data (fifo_data),
      .fifo_empty(fifo_empty),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   // Upstream FIFO: depth 8, registered o_data, pops only when non-empty.
   always @(posedge clk) begin
      if (fifo_rden && fifo_mem.size() != 0) fifo_data <= fifo_mem.pop_front();
      if (wr_en && fifo_mem.size() < 8) fifo_mem.push_back(wr_data);
      fifo_empty <= (fifo_mem.size() == 0);
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      bit was_busy;
      bit acc;
      logic [DW-1:0] w;
      if (rst) begin
         exp_busy   = 1'b0;
         exp_done   = 1'b0;
         owed       = 0;
         pops       = 0;
         outst      = 0;
         prev_stall = 1'b0;
         wr_log     = fifo_mem;
      end else begin
         was_busy = exp_busy;
         chk("busy", int'(busy), int'(exp_busy));
         chk("done", int'(done), int'(exp_done));
         exp_done = 1'b0;
         if (!exp_busy) chk("idle_valid", int'(m_valid), 0);
         if (prev_stall) begin
            chk("stall_valid", int'(m_valid), 1);
            chk("stall_data", int'(m_data), int'(prev_data));
            chk("stall_last", int'(m_last), int'(prev_last));
         end
         if (m_valid) chk("last", int'(m_last), int'(owed == 1));
         if (fifo_rden) begin
            chk("rden_empty", int'(fifo_empty), 0);
            chk("rden_busy", int'(exp_busy), 1);
            pops++;
            chk("overread", int'(pops <= burst_len), 1);
         end
         acc   = m_valid && m_ready;
         outst = outst + int'(fifo_rden) - int'(acc);
         chk("held_words", int'(outst <= 2), 1);
         if (acc) begin
            got.push_back(m_data);
            acc_cyc.push_back(cyc);
            if (wr_log.size() == 0 || owed == 0) begin
               chk("extra_beat", int'(m_data), -1);
            end else begin
               w = wr_log.pop_front();
               chk("data", int'(m_data), int'(w));
               owed--;
               if (owed == 0) begin
                  chk("pop_count", pops, burst_len);
                  exp_busy = 1'b0;
                  exp_done = 1'b1;
               end
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         if (!was_busy && start) begin
            if (len == '0) begin
               exp_done = 1'b1;
            end else begin
               exp_busy  = 1'b1;
               owed      = int'(len);
               burst_len = int'(len);
               pops      = 0;
               st_cyc    = cyc;
            end
         end
         if (wr_en) wr_log.push_back(wr_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = DW'(base + i);
         tick();
      end
      wr_en = 1'b0;
      tick();
   endtask

   task automatic issue(input int l);
      start = 1'b1;
      len   = LW'(l);
      tick();
      start = 1'b0;
   endtask

   task automatic run_until_idle(input int mode, input int budget);
      int n = 0;
      while (exp_busy && n < budget) begin
         case (mode)
            0: m_ready = 1'b1;
            1: m_ready = pat[n % 6];
            default: m_ready = ($urandom_range(0, 9) < 7);
         endcase
         if (mode == 2) begin
            wr_en   = (fifo_mem.size() < 6) && ($urandom_range(0, 1) == 1);
            wr_data = DW'($urandom);
         end
         tick();
         n++;
      end
      wr_en   = 1'b0;
      m_ready = 1'b1;
      chk("burst_timeout", int'(n < budget), 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_rden"}, int'(fifo_rden), 0);
      chk({tag, "_valid"}, int'(m_valid), 0);
      chk({tag, "_data"}, int'(m_data), 0);
      chk({tag, "_last"}, int'(m_last), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs("rst");
      rst = 1'b0;
      tick();

      // Preloaded 0x11..0x14, back-to-back beats from cycle 3.
      preload('h11, 4);
      got.delete();
      acc_cyc.delete();
      issue(4);
      run_until_idle(0, 50);
      chk("t1_count", got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_word", (i < got.size()) ? int'(got[i]) : -1, 'h11 + i);
         chk("t1_cycle", (i < acc_cyc.size()) ? acc_cyc[i] - st_cyc : -1, 3 + i);
      end
      tick();
      chk("t1_fifo_left", fifo_mem.size(), 0);

      // Partial drain leaves the rest in order.
      preload('h21, 8);
      issue(3);
      run_until_idle(0, 50);
      tick();
      chk("t2_fifo_left", fifo_mem.size(), 5);
      got.delete();
      issue(5);
      run_until_idle(0, 50);
      chk("t2_count", got.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk("t2_word", (i < got.size()) ? int'(got[i]) : -1, 'h24 + i);
      end

      // Consumer back-pressure.
      preload('h31, 4);
      got.delete();
      issue(4);
      run_until_idle(1, 100);
      chk("t3_count", got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t3_word", (i < got.size()) ? int'(got[i]) : -1, 'h31 + i);
      end

      // Empty FIFO at start; writer trickles data in.
      got.delete();
      issue(2);
      for (int t = 1; t < 60 && exp_busy; t++) begin
         wr_en   = (t == 5) || (t == 9);
         wr_data = (t == 5) ? 8'hA0 : 8'hA1;
         tick();
      end
      wr_en = 1'b0;
      chk("t4_timeout", int'(exp_busy), 0);
      chk("t4_count", got.size(), 2);
      chk("t4_w0", (got.size() > 0) ? int'(got[0]) : -1, 'hA0);
      chk("t4_w1", (got.size() > 1) ? int'(got[1]) : -1, 'hA1);
      tick();

      // Zero length, then a start during a busy burst.
      issue(0);
      chk("t5_len0_done", int'(done), 1);
      chk("t5_len0_busy", int'(busy), 0);
      tick();
      preload('h51, 3);
      got.delete();
      issue(3);
      start = 1'b1;
      len   = LW'(5);
      tick();
      start = 1'b0;
      run_until_idle(0, 50);
      chk("t5_count", got.size(), 3);
      tick();
      chk("t5_fifo_left", fifo_mem.size(), 0);

      // Reset in the middle of a burst.
      preload('h61, 6);
      got.delete();
      issue(6);
      for (int t = 0; t < 50 && got.size() < 2; t++) tick();
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outs("mid_rst");
      tick();
      tick();
      rst = 1'b0;
      tick();
      got.delete();
      issue(2);
      run_until_idle(0, 50);
      chk("t6_count", got.size(), 2);
      chk("t6_order", (got.size() > 1) ? int'(got[1]) - int'(got[0]) : -1, 1);
      tick();
      while (fifo_mem.size() != 0) begin
         issue(fifo_mem.size());
         run_until_idle(0, 50);
      end

      // Random bursts, random back-pressure, random writer.
      for (int b = 0; b < 14; b++) begin
         issue($urandom_range(0, 6));
         run_until_idle(2, 400);
         tick();
      end

      // Maximum length burst.
      issue((1 << LW) - 1);
      run_until_idle(2, 5000);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
